// File: rtl/ws2812_frame_ctrl.sv
// ws2812_frame_ctrl
//   Frame sequencer for a WS2812 strip. Holds a NUM_LEDS-deep RGB pixel
//   buffer. On start it streams brightness-scaled pixels in GRB order to the
//   downstream bit serializer over a valid/ready handshake. After the last
//   pixel it holds the latch gap for RESET_CYCLES clocks. With auto_refresh
//   set, frames run back to back.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data buffer write port (RGB {R,G,B}), any state
//   num_leds, brightness frame length and global scale, sampled at frame start
//   start, auto_refresh  frame request / loop frames after each gap
//   busy, frame_done     frame in progress / one-cycle end-of-gap pulse
//   px_valid/px_ready    pixel handshake to the serializer
//   px_data, px_last     scaled pixel {G,R,B}, final-pixel flag
module ws2812_frame_ctrl #(
  parameter int unsigned NUM_LEDS     = 8,
  parameter int unsigned ADDR_W       = 3,
  parameter int unsigned RESET_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic [ADDR_W:0]   num_leds,
  input  logic [7:0]        brightness,
  input  logic              start,
  input  logic              auto_refresh,
  output logic              busy,
  output logic              frame_done,
  output logic              px_valid,
  input  logic              px_ready,
  output logic [23:0]       px_data,
  output logic              px_last
);

  localparam int unsigned       CNT_W    = $clog2(RESET_CYCLES + 1);
  localparam logic [ADDR_W:0]   MAX_N    = (ADDR_W + 1)'(NUM_LEDS);
  localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SCALE,
    S_SEND,
    S_GAP
  } state_t;

  state_t            state_q;
  logic [ADDR_W:0]   n_q;
  logic [7:0]        bright_q;
  logic [ADDR_W-1:0] idx_q;
  logic [CNT_W-1:0]  gap_q;
  logic [23:0]       rd_q;
  logic              busy_q;
  logic              frame_done_q;
  logic              px_valid_q;
  logic [23:0]       px_data_q;
  logic              px_last_q;

  logic [23:0]       mem [NUM_LEDS];
  logic [ADDR_W:0]   n_clamp;
  logic [23:0]       px_data_d;
  logic              px_last_d;

  // c * (b + 1) >> 8: b = 255 is identity, b = 0 blanks the channel.
  function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
    logic [16:0] p;
    p = {9'd0, c} * ({9'd0, b} + 17'd1);
    return 8'(p >> 8);
  endfunction

  // Pixel buffer: no reset, out-of-range addresses dropped.
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < MAX_N)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    n_clamp   = (num_leds > MAX_N) ? MAX_N : num_leds;
    px_data_d = {scale8(rd_q[15:8], bright_q),
                 scale8(rd_q[23:16], bright_q),
                 scale8(rd_q[7:0], bright_q)};
    px_last_d = ({1'b0, idx_q} == (n_q - 1'b1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      bright_q     <= '0;
      idx_q        <= '0;
      gap_q        <= '0;
      rd_q         <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      px_valid_q   <= 1'b0;
      px_data_q    <= '0;
      px_last_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            n_q      <= n_clamp;
            bright_q <= brightness;
            idx_q    <= '0;
            gap_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= (n_clamp == '0) ? S_GAP : S_FETCH;
          end
        end
        S_FETCH: begin
          rd_q    <= mem[idx_q];
          state_q <= S_SCALE;
        end
        S_SCALE: begin
          px_data_q  <= px_data_d;
          px_last_q  <= px_last_d;
          px_valid_q <= 1'b1;
          state_q    <= S_SEND;
        end
        S_SEND: begin
          if (px_ready) begin
            px_valid_q <= 1'b0;
            px_last_q  <= 1'b0;
            if (px_last_q) begin
              gap_q   <= '0;
              state_q <= S_GAP;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= S_FETCH;
            end
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            frame_done_q <= 1'b1;
            gap_q        <= '0;
            if (auto_refresh) begin
              // Relatch exactly as a fresh start would; busy stays high.
              n_q      <= n_clamp;
              bright_q <= brightness;
              idx_q    <= '0;
              state_q  <= (n_clamp == '0) ? S_GAP : S_FETCH;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign px_valid   = px_valid_q;
  assign px_data    = px_data_q;
  assign px_last    = px_last_q;

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Testbench for ws2812_frame_ctrl: randomized pixel data, lengths,
// brightness and back-pressure against a behavioural frame model.
module tb_ws2812_frame_ctrl;

  localparam int NL = 8;
  localparam int AW = 3;
  localparam int RC = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic [AW:0]   num_leds;
  logic [7:0]    brightness;
  logic          start;
  logic          auto_refresh;
  logic          busy;
  logic          frame_done;
  logic          px_valid;
  logic          px_ready;
  logic [23:0]   px_data;
  logic          px_last;

  int checks = 0;
  int passed = 0;
  logic [23:0] buf_m [NL];

  always #5 clk = ~clk;

  ws2812_frame_ctrl #(
    .NUM_LEDS    (NL),
    .ADDR_W      (AW),
    .RESET_CYCLES(RC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .num_leds    (num_leds),
    .brightness  (brightness),
    .start       (start),
    .auto_refresh(auto_refresh),
    .busy        (busy),
    .frame_done  (frame_done),
    .px_valid    (px_valid),
    .px_ready    (px_ready),
    .px_data     (px_data),
    .px_last     (px_last)
  );

  // Reference: each channel scaled by (brightness+1)/256, rounded down,
  // emitted as {G,R,B}.
  function automatic int scale_ch(input int c, input int b);
    return (c * (b + 1)) / 256;
  endfunction

  function automatic logic [23:0] model_px(input logic [23:0] rgb, input int b);
    int r, g, bl;
    r  = scale_ch(int'(rgb[23:16]), b);
    g  = scale_ch(int'(rgb[15:8]), b);
    bl = scale_ch(int'(rgb[7:0]), b);
    return {8'(g), 8'(r), 8'(bl)};
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic write_px(input int a, input logic [23:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    tick;
    wr_en = 1'b0;
    if (a < NL) buf_m[a] = d;
  endtask

  task automatic start_frame(input int n_req, input int b);
    num_leds   = (AW + 1)'(n_req);
    brightness = 8'(b);
    start      = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // Entered at the negedge right after the frame-start edge. Checks latency,
  // pixel contents/order, stall stability, gap length and completion.
  task automatic collect_frame(input int n_req, input int b, input bit auto_on,
                               input bit rand_stall, input int stall_px,
                               input int stall_len, input bit disturb);
    int n, len, i, waited;
    logic [23:0] hold, expv, newv;
    logic        hold_last;
    n = (n_req > NL) ? NL : n_req;
    checks++;
    if (busy !== 1'b1) $display("FAIL busy_at_start: got %b, required 1", busy);
    else passed++;
    for (int k = 0; k < n; k++) begin
      checks++;
      if (px_valid !== 1'b0) $display("FAIL bubble0 px%0d: got %b, required 0", k, px_valid);
      else passed++;
      tick;
      checks++;
      if (px_valid !== 1'b0) $display("FAIL bubble1 px%0d: got %b, required 0", k, px_valid);
      else passed++;
      tick;
      checks++;
      if (px_valid !== 1'b1) $display("FAIL latency px%0d: got %b, required 1", k, px_valid);
      else passed++;
      waited = 0;
      while (px_valid !== 1'b1 && waited < 20) begin
        tick;
        waited++;
      end
      if (px_valid !== 1'b1) begin
        checks++;
        $display("FAIL timeout px%0d: no px_valid within 20 cycles", k);
        return;
      end
      expv = model_px(buf_m[k], b);
      checks++;
      if (px_data !== expv) $display("FAIL data px%0d: got %06h, required %06h", k, px_data, expv);
      else passed++;
      checks++;
      if (px_last !== (k == n - 1)) $display("FAIL last px%0d: got %b, required %b", k, px_last, (k == n - 1));
      else passed++;
      hold      = px_data;
      hold_last = px_last;
      len = rand_stall ? int'($urandom_range(0, 3)) : ((k == stall_px) ? stall_len : 0);
      if (disturb && k == 0 && len < 2) len = 2;
      for (int s = 0; s < len; s++) begin
        if (disturb && k == 0 && s == 0) begin
          newv       = 24'($urandom);
          wr_en      = 1'b1;
          wr_addr    = AW'(2);
          wr_data    = newv;
          start      = 1'b1;
          num_leds   = (AW + 1)'($urandom);
          brightness = 8'($urandom);
        end
        tick;
        if (disturb && k == 0 && s == 0) begin
          wr_en    = 1'b0;
          start    = 1'b0;
          buf_m[2] = newv;
        end
        checks++;
        if (px_valid !== 1'b1 || px_data !== hold || px_last !== hold_last)
          $display("FAIL stall px%0d cyc%0d: got v=%b d=%06h l=%b, required v=1 d=%06h l=%b",
                   k, s, px_valid, px_data, px_last, hold, hold_last);
        else passed++;
      end
      px_ready = 1'b1;
      tick;
      px_ready = 1'b0;
    end
    for (i = 1; i <= RC + 20; i++) begin
      tick;
      if (frame_done === 1'b1) break;
      checks++;
      if (px_valid !== 1'b0 || busy !== 1'b1)
        $display("FAIL gap cyc%0d: got valid=%b busy=%b, required valid=0 busy=1", i, px_valid, busy);
      else passed++;
    end
    checks++;
    if (i !== RC) $display("FAIL gap_len: got %0d, required %0d", i, RC);
    else passed++;
    checks++;
    if (busy !== auto_on) $display("FAIL busy_at_done: got %b, required %b", busy, auto_on);
    else passed++;
    if (!auto_on) begin
      tick;
      checks++;
      if (frame_done !== 1'b0 || busy !== 1'b0)
        $display("FAIL after_done: got done=%b busy=%b, required 0 0", frame_done, busy);
      else passed++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    checks++;
    if ({busy, frame_done, px_valid, px_last} !== 4'b0 || px_data !== 24'h0)
      $display("FAIL reset_outputs: got b=%b d=%b v=%b l=%b data=%06h, required all 0",
               busy, frame_done, px_valid, px_last, px_data);
    else passed++;
    rst = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0 || px_valid !== 1'b0)
      $display("FAIL post_reset_idle: got busy=%b valid=%b, required 0 0", busy, px_valid);
    else passed++;
  endtask

  task automatic test_basic;
    write_px(0, 24'hFF0000);
    write_px(1, 24'h00FF00);
    write_px(2, 24'h0000FF);
    start_frame(3, 255);
    collect_frame(3, 255, 1'b0, 1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_scale;
    write_px(0, 24'h80FF01);
    start_frame(1, 127);
    collect_frame(1, 127, 1'b0, 1'b0, -1, 0, 1'b0);
    start_frame(1, 0);
    collect_frame(1, 0, 1'b0, 1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_stall;
    int b;
    for (int a = 0; a < 3; a++) write_px(a, 24'($urandom));
    b = int'($urandom_range(0, 255));
    start_frame(3, b);
    collect_frame(3, b, 1'b0, 1'b0, 1, 10, 1'b0);
  endtask

  task automatic test_limits;
    int b;
    start_frame(0, 255);
    collect_frame(0, 255, 1'b0, 1'b0, -1, 0, 1'b0);
    for (int a = 0; a < NL; a++) write_px(a, 24'($urandom));
    b = int'($urandom_range(0, 255));
    start_frame(15, b);
    collect_frame(15, b, 1'b0, 1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_back_to_back;
    for (int a = 0; a < 3; a++) write_px(a, 24'($urandom));
    auto_refresh = 1'b1;
    start_frame(2, 200);
    num_leds   = (AW + 1)'(3);
    brightness = 8'd60;
    collect_frame(2, 200, 1'b1, 1'b0, -1, 0, 1'b0);
    auto_refresh = 1'b0;
    collect_frame(3, 60, 1'b0, 1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_midframe;
    int b;
    for (int a = 0; a < 3; a++) write_px(a, 24'($urandom));
    b = int'($urandom_range(0, 255));
    start_frame(3, b);
    collect_frame(3, b, 1'b0, 1'b0, -1, 0, 1'b1);
  endtask

  task automatic test_random;
    int n, b;
    for (int f = 0; f < 8; f++) begin
      for (int w = 0; w < 4; w++) write_px(int'($urandom_range(0, NL - 1)), 24'($urandom));
      n = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 255));
      start_frame(n, b);
      collect_frame(n, b, 1'b0, 1'b1, -1, 0, 1'b0);
    end
  endtask

  task automatic test_reset_mid;
    int  waited;
    bit  seen_done;
    write_px(0, 24'($urandom));
    start_frame(1, 255);
    waited = 0;
    while (px_valid !== 1'b1 && waited < 20) begin
      tick;
      waited++;
    end
    checks++;
    if (px_valid !== 1'b1 || px_last !== 1'b1)
      $display("FAIL pre_reset_send: got valid=%b last=%b, required 1 1", px_valid, px_last);
    else passed++;
    rst = 1'b1;
    #1;
    checks++;
    if (px_valid !== 1'b0 || busy !== 1'b0 || px_last !== 1'b0 || frame_done !== 1'b0)
      $display("FAIL async_reset: got v=%b b=%b l=%b d=%b, required all 0",
               px_valid, busy, px_last, frame_done);
    else passed++;
    tick;
    rst = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < RC + 20; c++) begin
      tick;
      if (frame_done === 1'b1 || busy === 1'b1 || px_valid === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done) $display("FAIL reset_no_done: got activity after reset, required none");
    else passed++;
    for (int a = 0; a < 3; a++) write_px(a, 24'($urandom));
    start_frame(3, 255);
    collect_frame(3, 255, 1'b0, 1'b0, -1, 0, 1'b0);
  endtask

  initial begin
    rst          = 1'b1;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    num_leds     = '0;
    brightness   = '0;
    start        = 1'b0;
    auto_refresh = 1'b0;
    px_ready     = 1'b0;
    test_reset;
    test_basic;
    test_scale;
    test_stall;
    test_limits;
    test_back_to_back;
    test_midframe;
    test_random;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

endmodule
